// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle fetch/decode/execute CPU with a ready-handshaked bus.
// Each instruction is two bus words: word0 (op/rd/cond/sub) and word1 (imm, or
// aluop/rs in register form). States IDLE -> F0 -> F1 -> EX -> [MEM] -> F0;
// HALTED is left only by reset.
// Ports:
//   clk, reset (async, active-low)
//   bus_addr/bus_wdata/bus_rd/bus_wr : bus request, held stable until bus_ready
//   bus_rdata/bus_ready              : read data and transfer completion
//   flags {N,V,Z,C}, halt, illegal   : architectural status
module cpu_core_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h2000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic              bus_ready,
  output logic [3:0]        flags,
  output logic              halt,
  output logic              illegal
);
  localparam int RW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int XW  = ADDR_W + DATA_W;
  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F0   = 3'd1;
  localparam logic [2:0] S_F1   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] word0, word1;
  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0]    op, sel, aop;
  logic [RW-1:0] rd_i, rs_i;
  logic          flag_c;

  assign op     = word0[7:4];
  assign sel    = word0[3:0];
  assign flag_c = flags[0];
  // register fields wrap modulo NREGS
  assign rd_i = RW'({1'b0, sel} % 5'(NREGS));
  assign rs_i = RW'({1'b0, word1[3:0]} % 5'(NREGS));

  // ALU: a is always R[rd]; src is the immediate or R[rs] in register form
  logic [DATA_W-1:0] a, src, res;
  logic [DATA_W:0]   add, sub;
  logic              cout, ovf;
  logic [3:0]        alu_flags;

  always_comb begin
    a   = regs[rd_i];
    src = (op == 4'h9) ? regs[rs_i] : word1;
    aop = (op == 4'h9) ? word1[7:4] : op;
    add = {1'b0, a} + {1'b0, src} + {{DATA_W{1'b0}}, (aop == 4'h7) & flag_c};
    // bit DATA_W of the extended difference is the borrow
    sub = {1'b0, a} - {1'b0, src} - {{DATA_W{1'b0}}, (aop == 4'h8) & flag_c};
    res  = a;
    cout = flag_c;
    ovf  = 1'b0;
    case (aop)
      4'h0, 4'h7: begin
        res  = add[MSB:0];
        cout = add[DATA_W];
        ovf  = (a[MSB] == src[MSB]) && (res[MSB] != a[MSB]);
      end
      4'h1, 4'h6, 4'h8: begin
        res  = sub[MSB:0];
        cout = sub[DATA_W];
        ovf  = (a[MSB] != src[MSB]) && (res[MSB] != a[MSB]);
      end
      4'h2: res = a & src;
      4'h3: res = a | src;
      4'h4: res = a ^ src;
      4'h5: res = src;
      default: ;
    endcase
    alu_flags = {res[MSB], ovf, (res == '0), cout};
  end

  // decode checks and branch condition
  logic bad, taken;
  always_comb begin
    bad = 1'b0;
    case (op)
      4'h9:       bad = (word1[7:4] > 4'd8);
      4'hC:       bad = (sel > 4'd6);
      4'hD, 4'hE: bad = 1'b1;
      4'hF:       bad = !(sel inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7});
      default:    bad = 1'b0;
    endcase
    taken = 1'b0;
    case (sel)
      4'd0: taken = 1'b1;
      4'd1: taken = flags[1];
      4'd2: taken = !flags[1];
      4'd3: taken = flags[0];
      4'd4: taken = !flags[0];
      4'd5: taken = flags[3];
      4'd6: taken = flags[2];
      default: taken = 1'b0;
    endcase
  end

  // imm widened once: zero-extended for data addresses, sign-extended for branches
  logic [XW-1:0]     imm_zx, imm_sx;
  logic [ADDR_W-1:0] mem_addr, br_off;
  assign imm_zx   = XW'(word1);
  assign imm_sx   = {{ADDR_W{word1[MSB]}}, word1};
  assign mem_addr = imm_zx[ADDR_W-1:0];
  assign br_off   = imm_sx[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      word0   <= '0;
      word1   <= '0;
      flags   <= '0;
      halt    <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_F0;
        S_F0: if (bus_ready) begin
          word0 <= bus_rdata;
          pc    <= pc + ADDR_W'(1);
          state <= S_F1;
        end
        S_F1: if (bus_ready) begin
          word1 <= bus_rdata;
          pc    <= pc + ADDR_W'(1);
          state <= S_EX;
        end
        S_EX: begin
          if (bad) begin
            halt    <= 1'b1;
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            state <= S_F0;
            if (op <= 4'h9) begin
              flags <= alu_flags;
              if (aop != 4'h6) regs[rd_i] <= res;
            end else begin
              case (op)
                4'hA, 4'hB: state <= S_MEM;
                4'hC: if (taken) pc <= pc + br_off;
                4'hF: case (sel)
                  4'd0: flags[0] <= 1'b0;
                  4'd1: flags[1] <= 1'b0;
                  4'd2: flags[2] <= 1'b0;
                  4'd3: flags[3] <= 1'b0;
                  4'd7: begin
                    halt  <= 1'b1;
                    state <= S_HALT;
                  end
                  default: ;
                endcase
                default: ;
              endcase
            end
          end
        end
        S_MEM: if (bus_ready) begin
          if (op == 4'hA) begin
            regs[rd_i] <= bus_rdata;
            flags      <= {bus_rdata[MSB], 1'b0, (bus_rdata == '0), flag_c};
          end
          state <= S_F0;
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // bus outputs decode from registered state, so they hold steady through wait states
  always_comb begin
    bus_rd    = (state == S_F0) || (state == S_F1) || (state == S_MEM && op == 4'hA);
    bus_wr    = (state == S_MEM) && (op == 4'hB);
    bus_addr  = '0;
    if (state == S_F0 || state == S_F1) bus_addr = pc;
    else if (state == S_MEM)            bus_addr = mem_addr;
    bus_wdata = bus_wr ? regs[rd_i] : '0;
  end
endmodule

// File: tb/tb_cpu_core_p.sv
module tb_cpu_core_p;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bus_addr;
  logic [7:0]  bus_rdata = 8'h00;
  logic [7:0]  bus_wdata;
  logic        bus_rd, bus_wr;
  logic        bus_ready = 1'b0;
  logic [3:0]  flags;
  logic        halt, illegal;

  always #5 clk = ~clk;

  cpu_core_p dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_rdata(bus_rdata),
    .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(bus_ready),
    .flags(flags), .halt(halt), .illegal(illegal)
  );

  typedef struct {bit wr; int addr; int data;} xact_t;
  xact_t exp_q[$];

  logic [7:0] mem [0:65535];   // memory seen by the DUT
  logic [7:0] im  [0:65535];   // reference model's private copy

  int n_cmp = 0, n_fail = 0;
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc;
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0; else cyc <= cyc + 1;

  // bus responder + scoreboard monitor
  int  rdy_pct = 100;
  bit  tab_en = 0;
  int  wait_tab [0:15];
  bit  allow_extra = 0;
  int  wait_left = -1, xidx = 0, tot_wait = 0, n_wr = 0;
  bit  prev_pend = 0;
  logic [25:0] snap;

  always @(negedge clk) begin
    if (!reset) begin
      wait_left = -1; xidx = 0; tot_wait = 0; n_wr = 0; prev_pend = 0; bus_ready = 0;
    end else if (bus_rd || bus_wr) begin
      if (prev_pend) check("req_stable_in_wait", {bus_rd, bus_wr, bus_addr, bus_wdata}, snap);
      if (wait_left < 0)
        wait_left = tab_en ? ((xidx < 16) ? wait_tab[xidx] : 0)
                           : (($urandom_range(0, 99) < rdy_pct) ? 0 : int'($urandom_range(1, 3)));
      bus_rdata = mem[bus_addr];
      if (wait_left > 0) begin
        bus_ready = 0; wait_left--; tot_wait++; prev_pend = 1;
        snap = {bus_rd, bus_wr, bus_addr, bus_wdata};
      end else begin
        bus_ready = 1; wait_left = -1; prev_pend = 0; xidx++;
        check("rd_wr_exclusive", bus_rd & bus_wr, 0);
        if (bus_wr) begin mem[bus_addr] = bus_wdata; n_wr++; end
        if (exp_q.size() == 0) begin
          if (!allow_extra) check("unexpected_xact", 1, 0);
        end else begin
          xact_t e;
          e = exp_q.pop_front();
          check("xact_is_write", bus_wr, e.wr);
          check("xact_addr", bus_addr, e.addr);
          if (e.wr) check("xact_wdata", bus_wdata, e.data);
        end
      end
    end else begin
      bus_ready = 1'($urandom_range(0, 1));  // must be ignored outside requests
      prev_pend = 0; wait_left = -1;
    end
  end

  // reference model: instruction-level interpreter
  int m_regs [16];
  bit mn, mv, mz, mc, m_halt, m_ill;
  int m_cyc;

  function automatic int sx8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic push(input bit wr, input int addr, input int data);
    xact_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic m_alu(input int op, input int d, input int b);
    int a, s, sv, r, ci;
    a = m_regs[d];
    r = 0;
    if (op == 0 || op == 7) begin
      ci = (op == 7) ? int'(mc) : 0;
      s = a + b + ci; r = s % 256; mc = (s > 255);
      sv = sx8(a) + sx8(b) + ci; mv = (sv > 127 || sv < -128);
    end else if (op == 1 || op == 6 || op == 8) begin
      ci = (op == 8) ? int'(mc) : 0;
      s = a - b - ci; r = (s + 512) % 256; mc = (s < 0);
      sv = sx8(a) - sx8(b) - ci; mv = (sv > 127 || sv < -128);
    end else begin
      case (op)
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        default: r = b;
      endcase
      mv = 0;
    end
    mz = (r == 0); mn = (r >= 128);
    if (op != 6) m_regs[d] = r;
  endtask

  task automatic iss_run(input int max_instr);
    int pc, w0, w1, op, x, cnt;
    bit t;
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    {mn, mv, mz, mc, m_halt, m_ill} = '0;
    m_cyc = 1; pc = 'h2000; cnt = 0;
    while (!m_halt && cnt < max_instr) begin
      w0 = int'(im[pc]); push(0, pc, 0); pc = (pc + 1) & 'hFFFF;
      w1 = int'(im[pc]); push(0, pc, 0); pc = (pc + 1) & 'hFFFF;
      m_cyc += 3; cnt++;
      op = w0 / 16; x = w0 % 16;
      if (op <= 8) m_alu(op, x, w1);
      else if (op == 9) begin
        if (w1 / 16 > 8) m_ill = 1; else m_alu(w1 / 16, x, m_regs[w1 % 16]);
      end else if (op == 10) begin
        push(0, w1, 0); m_regs[x] = int'(im[w1]);
        mz = (m_regs[x] == 0); mn = (m_regs[x] >= 128); mv = 0; m_cyc++;
      end else if (op == 11) begin
        push(1, w1, m_regs[x]); im[w1] = 8'(m_regs[x]); m_cyc++;
      end else if (op == 12) begin
        t = 0;
        case (x)
          0: t = 1;   1: t = mz;  2: t = !mz; 3: t = mc;
          4: t = !mc; 5: t = mn;  6: t = mv;
          default: m_ill = 1;
        endcase
        if (t) pc = (pc + sx8(w1)) & 'hFFFF;
      end else if (op == 15) begin
        case (x)
          0: mc = 0; 1: mz = 0; 2: mv = 0; 3: mn = 0;
          6: ;
          7: m_halt = 1;
          default: m_ill = 1;
        endcase
      end else m_ill = 1;
      if (m_ill) m_halt = 1;
    end
  endtask

  task automatic put2(input int addr, input int w0, input int w1);
    mem[addr] = 8'(w0); mem[addr + 1] = 8'(w1);
  endtask

  task automatic clear_code();
    for (int i = 'h2000; i < 'h2400; i++) mem[i] = 8'hF7;
  endtask

  // reset, build expectations, release, then run to halt (or drain a non-halting stream)
  task automatic run_prog(input int max_instr, input bit expect_halt, output int hcyc);
    int t;
    logic act;
    reset = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 65536; i++) im[i] = mem[i];
    iss_run(max_instr);
    allow_extra = !expect_halt;
    @(negedge clk) reset = 1;
    t = 0;
    hcyc = 0;
    if (expect_halt) begin
      while (!halt && t < 4000) begin @(negedge clk); t++; end
      check("halt_reached", halt, 1);
      hcyc = cyc;
      check("halt_cycle_count", hcyc, m_cyc + tot_wait);
      check("scoreboard_drained", exp_q.size(), 0);
      check("final_flags", flags, {mn, mv, mz, mc});
      check("illegal_flag", illegal, m_ill);
      act = 0;
      repeat (4) begin @(negedge clk); act = act | bus_rd | bus_wr; end
      check("bus_quiet_after_halt", act, 0);
      check("halt_sticky", halt, 1);
    end else begin
      while (exp_q.size() > 0 && t < 4000) begin @(negedge clk); t++; end
      check("stream_drained", exp_q.size(), 0);
    end
  endtask

  task automatic gen_random();
    int p, k, r, w0, w1;
    int sys_tab [5] = '{0, 1, 2, 3, 6};
    clear_code();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    p = 'h2000;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 9));
      r = int'($urandom_range(0, 15));
      w1 = int'($urandom_range(0, 255));
      case (k)
        3: begin
          w0 = 'h90 | r;
          w1 = (($urandom_range(0, 15) == 0) ? int'($urandom_range(9, 15))
                                              : int'($urandom_range(0, 8))) * 16
               + int'($urandom_range(0, 15));
        end
        4: w0 = 'hA0 | r;
        5: w0 = 'hB0 | r;
        6: begin
          w0 = 'hC0 | (($urandom_range(0, 24) == 0) ? int'($urandom_range(7, 15))
                                                     : int'($urandom_range(0, 6)));
          w1 = int'($urandom_range(0, 4)) * 2;
        end
        7: w0 = ($urandom_range(0, 30) == 0) ? 'hD0 : ('hF0 | sys_tab[$urandom_range(0, 4)]);
        default: w0 = int'($urandom_range(0, 8)) * 16 + r;
      endcase
      put2(p, w0, w1); p += 2;
    end
    for (int i = 0; i < 16; i++) begin put2(p, 'hB0 | i, 'hE0 + i); p += 2; end
    put2(p, 'hF7, 0);
  endtask

  int h, tt;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) wait_tab[i] = 0;

    repeat (2) @(negedge clk);
    check("reset_bus_idle", {bus_rd, bus_wr}, 0);
    check("reset_bus_addr", bus_addr, 0);
    check("reset_wdata", bus_wdata, 0);
    check("reset_status", {flags, halt, illegal}, 0);

    // ADD imm then ADD: R1=0x10, C=1
    clear_code();
    put2('h2000, 'h51, 'hF0); put2('h2002, 'h01, 'h20);
    put2('h2004, 'hB1, 'h50); put2('h2006, 'hF7, 'h00);
    run_prog(1000, 1, h);
    check("add_total_cycles", h, 14);
    check("add_flags", flags, 4'b0001);
    check("add_r1_value", mem['h50], 'h10);

    // SUB to zero, then CMP leaves R1 intact
    clear_code();
    mem['h50] = 8'hAA; mem['h51] = 8'hAA;
    put2('h2000, 'h51, 'hF0); put2('h2002, 'h01, 'h20); put2('h2004, 'h11, 'h10);
    put2('h2006, 'hB1, 'h50); put2('h2008, 'h61, 'h01); put2('h200A, 'hB1, 'h51);
    put2('h200C, 'hF7, 0);
    run_prog(1000, 1, h);
    check("sub_result", mem['h50], 0);
    check("cmp_keeps_rd", mem['h51], 0);
    check("cmp_flags", flags, 4'b1001);

    // BEQ taken and not taken (illegal words sit on the wrong path)
    clear_code();
    put2('h2000, 'h51, 'h00); put2('h2002, 'hC1, 'h04);
    put2('h2004, 'hD0, 0); put2('h2006, 'hD0, 0); put2('h2008, 'hF7, 0);
    run_prog(1000, 1, h);
    check("beq_taken_no_illegal", illegal, 0);
    check("beq_taken_cycles", h, 10);
    clear_code();
    put2('h2000, 'h51, 'h01); put2('h2002, 'hC1, 'h04);
    put2('h2004, 'hF7, 0); put2('h2008, 'hD0, 0);
    run_prog(1000, 1, h);
    check("beq_fallthru_no_illegal", illegal, 0);

    // BRA -2 loops on its own address
    clear_code();
    put2('h2000, 'hC0, 'hFE);
    run_prog(6, 0, h);

    // undefined opcode traps
    clear_code();
    put2('h2000, 'hD0, 0);
    run_prog(1000, 1, h);
    check("illegal_d0", {halt, illegal}, 2'b11);

    // wait states in F1 and MEM of a store
    clear_code();
    put2('h2000, 'h52, 'h5A); put2('h2002, 'hB2, 'h40); put2('h2004, 'hF7, 0);
    wait_tab[3] = 2; wait_tab[4] = 1; tab_en = 1;
    run_prog(1000, 1, h);
    check("st_wait_total_cycles", h, 14);
    check("st_single_write", n_wr, 1);
    check("st_mem_value", mem['h40], 'h5A);
    tab_en = 0; wait_tab[3] = 0; wait_tab[4] = 0;

    // random programs with random wait states
    rdy_pct = 60;
    for (int n = 0; n < 8; n++) begin
      gen_random();
      run_prog(1000, 1, h);
    end
    rdy_pct = 100;

    // asynchronous reset in the middle of a stalled F1
    clear_code();
    put2('h2000, 'h51, 'hF0); put2('h2002, 'hF7, 0);
    wait_tab[1] = 20; tab_en = 1;
    reset = 0;
    repeat (2) @(negedge clk);
    exp_q.delete(); allow_extra = 1;
    @(negedge clk) reset = 1;
    tt = 0;
    while (!(bus_rd && bus_addr == 16'h2001) && tt < 50) begin @(negedge clk); tt++; end
    check("reached_f1", bus_rd && bus_addr == 16'h2001, 1);
    #1 reset = 0;
    #1 check("async_reset_drops_rd", bus_rd, 0);
    @(negedge clk) reset = 1;
    #1 check("idle_after_release", bus_rd, 0);
    @(negedge clk);
    check("first_fetch_rd", bus_rd, 1);
    check("first_fetch_addr", bus_addr, 'h2000);
    tab_en = 0; wait_tab[1] = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
